// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: funct3 codes, buffer entry type and access-size helper shared by store_buffer.
// Build option: define STORE_BUFFER_FORWARD_EN to enable store-to-load forwarding.
package store_buffer_pkg;

    localparam int SB_AW = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic [2:0]       funct3;
        logic [SB_AW-1:0] addr;
        logic [31:0]      data;
    } sb_entry_t;

    // Access size in bytes: low funct3 bits select byte, half or word.
    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        return funct3[1] ? 3'd4 : (funct3[0] ? 3'd2 : 3'd1);
    endfunction

endpackage

// File: rtl/sb_overlap.sv
// sb_overlap: byte-range overlap and exact-match test of one buffered store against the current load.
// Build option: STORE_BUFFER_FORWARD_EN builds the exact-match comparator; otherwise exact_o is 0.
module sb_overlap import store_buffer_pkg::*; #(
    parameter int AW = 32
) (
    input  logic          valid_i,
    input  logic [2:0]    st_funct3_i,
    input  logic [AW-1:0] st_addr_i,
    input  logic [2:0]    ld_funct3_i,
    input  logic [AW-1:0] ld_addr_i,
    output logic          overlap_o,
    output logic          exact_o
);

    logic [AW-1:0] st_sz, ld_sz;

    assign st_sz = AW'(size_of(st_funct3_i));
    assign ld_sz = AW'(size_of(ld_funct3_i));

    // Modular distance keeps the test correct when a range wraps past the top of the address space.
    assign overlap_o = valid_i && ((ld_addr_i - st_addr_i) < st_sz || (st_addr_i - ld_addr_i) < ld_sz);

`ifdef STORE_BUFFER_FORWARD_EN
    localparam int AW1 = AW + 1;
    logic [AW:0] st_last;

    // A carry out of the last byte address means the access wraps and is not forwarded.
    assign st_last = {1'b0, st_addr_i} + AW1'(st_sz) - AW1'(1);
    assign exact_o = valid_i && st_addr_i == ld_addr_i && st_sz == ld_sz && !st_last[AW];
`else
    assign exact_o = 1'b0;
`endif

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-store FIFO between MEM stage and data memory with load forwarding/stall detection.
// Build option: STORE_BUFFER_FORWARD_EN enables forwarding; undefined, every overlap stalls the load.
module store_buffer import store_buffer_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid_i,
    input  logic [2:0]    st_funct3_i,
    input  logic [AW-1:0] st_addr_i,
    input  logic [31:0]   st_data_i,
    output logic          st_ready_o,
    input  logic          ld_valid_i,
    input  logic [2:0]    ld_funct3_i,
    input  logic [AW-1:0] ld_addr_i,
    output logic          ld_hit_o,
    output logic          ld_conflict_o,
    output logic [31:0]   ld_fwd_data_o,
    input  logic          fence_req_i,
    output logic          empty_o,
    output logic          mem_write_o,
    output logic [2:0]    mem_funct3_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    sb_entry_t        ent_q [DEPTH];
    logic [PW-1:0]    head_q, tail_q, head_d, tail_d, sel;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] ovl, exact;
    logic             st_ok, ld_ok, push, pop, found, fence_unused;
    logic [31:0]      d, ext;
    logic             sx;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ovl
        logic [PW-1:0] age;
        assign age = PW'(i) - head_q;
        sb_overlap #(.AW(AW)) u_ovl (
            .valid_i    (CW'(age) < count_q),
            .st_funct3_i(ent_q[i].funct3),
            .st_addr_i  (ent_q[i].addr[AW-1:0]),
            .ld_funct3_i(ld_funct3_i),
            .ld_addr_i  (ld_addr_i),
            .overlap_o  (ovl[i]),
            .exact_o    (exact[i])
        );
    end

    // Walk entries oldest to youngest so the youngest overlapping store is the one selected.
    always_comb begin
        found = 1'b0;
        sel   = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (ovl[head_q + PW'(k)]) begin
                found = 1'b1;
                sel   = head_q + PW'(k);
            end
        end
    end

    // Fences only hold the pipeline until empty; the buffer itself ignores them.
    assign fence_unused = fence_req_i;

    assign st_ok         = st_funct3_i inside {F3_B, F3_H, F3_W};
    assign ld_ok         = ld_valid_i && (ld_funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign ld_hit_o      = ld_ok && found && exact[sel];
    assign ld_conflict_o = ld_ok && found && !exact[sel];

    // Memory presents the lowest-addressed byte as the field MSB, so the store bytes are reversed.
    assign d   = ent_q[sel].data;
    assign sx  = !ld_funct3_i[2];
    assign ext = ld_funct3_i[1] ? {d[7:0], d[15:8], d[23:16], d[31:24]}
               : ld_funct3_i[0] ? {{16{sx & d[7]}}, d[7:0], d[15:8]}
               : {{24{sx & d[7]}}, d[7:0]};
    assign ld_fwd_data_o = ld_hit_o ? ext : 32'h0;

    assign empty_o      = count_q == '0;
    assign st_ready_o   = count_q != CW'(DEPTH);
    assign push         = st_valid_i && st_ready_o && st_ok;
    assign pop          = !empty_o && (!ld_valid_i || ld_conflict_o);
    assign mem_write_o  = pop;
    assign mem_funct3_o = ent_q[head_q].funct3;
    assign mem_addr_o   = ent_q[head_q].addr[AW-1:0];
    assign mem_wdata_o  = ent_q[head_q].data;

    // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // FIFO state; reset discards every pending store immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) ent_q[k] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) ent_q[tail_q] <= '{funct3: st_funct3_i, addr: SB_AW'(st_addr_i), data: st_data_i};
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed tests for store_buffer; expectations follow STORE_BUFFER_FORWARD_EN.
module tb_store_buffer;

`ifdef STORE_BUFFER_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        st_valid = 1'b0, ld_valid = 1'b0, fence_req = 1'b0;
    logic [2:0]  st_funct3 = 3'b010, ld_funct3 = 3'b010;
    logic [31:0] st_addr = '0, st_data = '0, ld_addr = '0;
    logic        st_ready, ld_hit, ld_conflict, empty, mem_write;
    logic [31:0] ld_fwd_data, mem_addr, mem_wdata;
    logic [2:0]  mem_funct3;
    int          errors = 0, checks = 0;

    store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid_i(st_valid), .st_funct3_i(st_funct3), .st_addr_i(st_addr), .st_data_i(st_data),
        .st_ready_o(st_ready),
        .ld_valid_i(ld_valid), .ld_funct3_i(ld_funct3), .ld_addr_i(ld_addr),
        .ld_hit_o(ld_hit), .ld_conflict_o(ld_conflict), .ld_fwd_data_o(ld_fwd_data),
        .fence_req_i(fence_req), .empty_o(empty),
        .mem_write_o(mem_write), .mem_funct3_o(mem_funct3), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_st(input bit v, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] dat);
        st_valid = v; st_funct3 = f3; st_addr = a; st_data = dat;
    endtask

    task automatic set_ld(input bit v, input logic [2:0] f3, input logic [31:0] a);
        ld_valid = v; ld_funct3 = f3; ld_addr = a;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_st(1, 3'b010, 32'h100, 32'hDEAD);
        repeat (2) tick;
        checks++;
        if ({empty, st_ready, mem_write, ld_hit, ld_conflict} !== 5'b11000) begin
            errors++; $display("FAIL reset_flags: got %b want 11000", {empty, st_ready, mem_write, ld_hit, ld_conflict});
        end
        checks++;
        if ({ld_fwd_data, mem_addr, mem_wdata, mem_funct3} !== '0) begin
            errors++; $display("FAIL reset_data: fwd=%h addr=%h wdata=%h f3=%b want 0", ld_fwd_data, mem_addr, mem_wdata, mem_funct3);
        end
        rst_n = 1'b1;
        set_st(0, 3'b010, 0, 0);
        tick;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL reset_enqueue: empty=%b want 1", empty); end
    endtask

    task automatic test_forward_word;
        set_st(1, 3'b010, 32'h100, 32'h11223344);
        set_ld(1, 3'b010, 32'h100);
        #1;
        checks++;
        if ({ld_hit, ld_conflict} !== 2'b00) begin errors++; $display("FAIL same_cycle_invisible: got %b want 00", {ld_hit, ld_conflict}); end
        tick;
        set_st(0, 3'b010, 0, 0);
        #1;
        checks++;
        if ({ld_hit, ld_conflict, mem_write} !== {FWD, !FWD, !FWD}) begin
            errors++; $display("FAIL lw_fwd_flags: got %b want %b", {ld_hit, ld_conflict, mem_write}, {FWD, !FWD, !FWD});
        end
        checks++;
        if (ld_fwd_data !== (FWD ? 32'h44332211 : 32'h0)) begin
            errors++; $display("FAIL lw_fwd_data: got %h want %h", ld_fwd_data, FWD ? 32'h44332211 : 32'h0);
        end
        set_ld(0, 3'b010, 0);
        tick;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL lw_drain: empty=%b want 1", empty); end
    endtask

    task automatic test_byte_half;
        set_st(1, 3'b000, 32'h203, 32'h80);
        tick;
        set_st(0, 3'b000, 0, 0);
        set_ld(1, 3'b000, 32'h203);
        #1;
        checks++;
        if (ld_fwd_data !== (FWD ? 32'hFFFFFF80 : 32'h0) || ld_conflict !== !FWD) begin
            errors++; $display("FAIL lb: data=%h conf=%b want %h %b", ld_fwd_data, ld_conflict, FWD ? 32'hFFFFFF80 : 32'h0, !FWD);
        end
        ld_funct3 = 3'b100;
        #1;
        checks++;
        if (ld_fwd_data !== (FWD ? 32'h80 : 32'h0) || ld_hit !== FWD) begin
            errors++; $display("FAIL lbu: data=%h hit=%b want %h %b", ld_fwd_data, ld_hit, FWD ? 32'h80 : 32'h0, FWD);
        end
        set_ld(0, 3'b000, 0);
        tick;
        set_st(1, 3'b001, 32'h600, 32'h0080);
        tick;
        set_st(0, 3'b000, 0, 0);
        set_ld(1, 3'b001, 32'h600);
        #1;
        checks++;
        if (ld_fwd_data !== (FWD ? 32'hFFFF8000 : 32'h0)) begin
            errors++; $display("FAIL lh: got %h want %h", ld_fwd_data, FWD ? 32'hFFFF8000 : 32'h0);
        end
        ld_funct3 = 3'b101;
        #1;
        checks++;
        if (ld_fwd_data !== (FWD ? 32'h00008000 : 32'h0)) begin
            errors++; $display("FAIL lhu: got %h want %h", ld_fwd_data, FWD ? 32'h00008000 : 32'h0);
        end
        ld_funct3 = 3'b000;
        #1;
        checks++;
        if ({ld_hit, ld_conflict, ld_fwd_data} !== {2'b01, 32'h0}) begin
            errors++; $display("FAIL size_mismatch: hit=%b conf=%b data=%h want 0 1 0", ld_hit, ld_conflict, ld_fwd_data);
        end
        ld_funct3 = 3'b011;
        #1;
        checks++;
        if ({ld_hit, ld_conflict, mem_write} !== 3'b000) begin
            errors++; $display("FAIL bad_ld_funct3: got %b want 000", {ld_hit, ld_conflict, mem_write});
        end
        set_ld(0, 3'b000, 0);
        tick;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL half_drain: empty=%b want 1", empty); end
        set_st(1, 3'b011, 32'h610, 32'h1);
        tick;
        set_st(0, 3'b000, 0, 0);
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL bad_st_funct3: empty=%b want 1", empty); end
    endtask

    task automatic test_conflict;
        set_st(1, 3'b001, 32'h300, 32'hBEEF);
        tick;
        set_st(0, 3'b000, 0, 0);
        set_ld(1, 3'b010, 32'h300);
        #1;
        checks++;
        if ({ld_conflict, ld_hit, mem_write} !== 3'b101) begin
            errors++; $display("FAIL conflict_flags: got %b want 101", {ld_conflict, ld_hit, mem_write});
        end
        checks++;
        if ({mem_funct3, mem_addr, mem_wdata} !== {3'b001, 32'h300, 32'hBEEF}) begin
            errors++; $display("FAIL conflict_drain: f3=%b addr=%h data=%h want 001 300 0000beef", mem_funct3, mem_addr, mem_wdata);
        end
        tick;
        checks++;
        if ({ld_conflict, ld_hit, mem_write, empty} !== 4'b0001) begin
            errors++; $display("FAIL conflict_clear: got %b want 0001", {ld_conflict, ld_hit, mem_write, empty});
        end
        set_st(1, 3'b010, 32'h500, 32'h5);
        set_ld(1, 3'b010, 32'h504);
        tick;
        set_st(0, 3'b000, 0, 0);
        checks++;
        if ({ld_hit, ld_conflict, mem_write, empty} !== 4'b0000) begin
            errors++; $display("FAIL disjoint: got %b want 0000", {ld_hit, ld_conflict, mem_write, empty});
        end
        ld_addr = 32'h4FD;
        #1;
        checks++;
        if ({ld_hit, ld_conflict} !== 2'b01) begin errors++; $display("FAIL partial_low: got %b want 01", {ld_hit, ld_conflict}); end
        ld_addr = 32'h4FC;
        #1;
        checks++;
        if ({ld_hit, ld_conflict} !== 2'b00) begin errors++; $display("FAIL adjacent_low: got %b want 00", {ld_hit, ld_conflict}); end
        set_ld(0, 3'b000, 0);
        tick;
    endtask

    task automatic test_wrap;
        set_ld(1, 3'b010, 32'h900);
        set_st(1, 3'b001, 32'hFFFFFFFF, 32'h1234);
        tick;
        set_st(0, 3'b000, 0, 0);
        set_ld(1, 3'b001, 32'hFFFFFFFF);
        #1;
        checks++;
        if ({ld_hit, ld_conflict} !== 2'b01) begin errors++; $display("FAIL wrap_exact: got %b want 01", {ld_hit, ld_conflict}); end
        set_ld(1, 3'b000, 32'h0);
        #1;
        checks++;
        if ({ld_hit, ld_conflict} !== 2'b01) begin errors++; $display("FAIL wrap_byte0: got %b want 01", {ld_hit, ld_conflict}); end
        set_ld(1, 3'b000, 32'h1);
        #1;
        checks++;
        if ({ld_hit, ld_conflict} !== 2'b00) begin errors++; $display("FAIL wrap_byte1: got %b want 00", {ld_hit, ld_conflict}); end
        set_ld(0, 3'b000, 0);
        tick;
        set_ld(1, 3'b010, 32'h900);
        set_st(1, 3'b010, 32'hFFFFFFFC, 32'hCAFEF00D);
        tick;
        set_st(0, 3'b000, 0, 0);
        set_ld(1, 3'b010, 32'hFFFFFFFC);
        #1;
        checks++;
        if ({ld_hit, ld_fwd_data} !== {FWD, FWD ? 32'h0DF0FECA : 32'h0}) begin
            errors++; $display("FAIL top_word: hit=%b data=%h want %b %h", ld_hit, ld_fwd_data, FWD, FWD ? 32'h0DF0FECA : 32'h0);
        end
        set_ld(0, 3'b000, 0);
        tick;
    endtask

    task automatic test_full;
        set_ld(1, 3'b010, 32'h900);
        for (int i = 0; i < 4; i++) begin
            set_st(1, 3'b010, 32'h10 + 32'(4 * i), 32'(i + 1));
            tick;
        end
        set_st(1, 3'b010, 32'h20, 32'h5);
        #1;
        checks++;
        if ({st_ready, mem_write, empty} !== 3'b000) begin
            errors++; $display("FAIL full_stall: got %b want 000", {st_ready, mem_write, empty});
        end
        tick;
        set_st(0, 3'b000, 0, 0);
        set_ld(0, 3'b000, 0);
        #1;
        checks++;
        if ({st_ready, mem_write, mem_addr, mem_wdata} !== {2'b01, 32'h10, 32'h1}) begin
            errors++; $display("FAIL full_head: rdy=%b wr=%b addr=%h data=%h want 0 1 10 1", st_ready, mem_write, mem_addr, mem_wdata);
        end
        tick;
        set_st(1, 3'b010, 32'h20, 32'h5);
        #1;
        checks++;
        if ({st_ready, mem_write, mem_addr, mem_wdata} !== {2'b11, 32'h14, 32'h2}) begin
            errors++; $display("FAIL push_pop: rdy=%b wr=%b addr=%h data=%h want 1 1 14 2", st_ready, mem_write, mem_addr, mem_wdata);
        end
        tick;
        set_st(0, 3'b000, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({mem_write, mem_addr, mem_wdata} !== {1'b1, 32'h18 + 32'(4 * i), 32'(3 + i)}) begin
                errors++; $display("FAIL drain_order[%0d]: wr=%b addr=%h data=%h want 1 %h %h", i, mem_write, mem_addr, mem_wdata, 32'h18 + 32'(4 * i), 3 + i);
            end
            tick;
        end
        checks++;
        if ({empty, st_ready, mem_write} !== 3'b110) begin
            errors++; $display("FAIL count_after_push_pop: got %b want 110", {empty, st_ready, mem_write});
        end
    endtask

    task automatic test_youngest_fence;
        set_ld(1, 3'b010, 32'h900);
        set_st(1, 3'b010, 32'h400, 32'hAAAAAAAA);
        tick;
        set_st(1, 3'b010, 32'h400, 32'h12345678);
        tick;
        set_st(0, 3'b000, 0, 0);
        set_ld(1, 3'b010, 32'h400);
        #1;
        checks++;
        if ({ld_hit, ld_conflict, ld_fwd_data} !== {FWD, !FWD, FWD ? 32'h78563412 : 32'h0}) begin
            errors++; $display("FAIL youngest: hit=%b conf=%b data=%h want %b %b %h", ld_hit, ld_conflict, ld_fwd_data, FWD, !FWD, FWD ? 32'h78563412 : 32'h0);
        end
        set_ld(0, 3'b000, 0);
        fence_req = 1'b1;
        #1;
        checks++;
        if ({mem_write, mem_wdata} !== {1'b1, 32'hAAAAAAAA}) begin
            errors++; $display("FAIL fence_first: wr=%b data=%h want 1 aaaaaaaa", mem_write, mem_wdata);
        end
        tick;
        checks++;
        if ({empty, mem_wdata} !== {1'b0, 32'h12345678}) begin
            errors++; $display("FAIL fence_second: empty=%b data=%h want 0 12345678", empty, mem_wdata);
        end
        tick;
        fence_req = 1'b0;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL fence_empty: empty=%b want 1", empty); end
    endtask

    task automatic test_reset_mid;
        set_st(1, 3'b010, 32'h700, 32'h77);
        tick;
        set_st(0, 3'b000, 0, 0);
        #1;
        checks++;
        if (mem_write !== 1'b1) begin errors++; $display("FAIL pre_reset_write: got %b want 1", mem_write); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_write, empty, st_ready} !== 3'b011) begin
            errors++; $display("FAIL async_reset: got %b want 011", {mem_write, empty, st_ready});
        end
        tick;
        rst_n = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_forward_word();
        test_byte_half();
        test_conflict();
        test_wrap();
        test_full();
        test_youngest_fence();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-store buffer between the MEM-stage pipeline register and the byte-addressed main data memory. Stores from the pipeline are accepted in one cycle and drained to memory in program order, one per cycle, whenever the memory port is not needed by a load. Loads are checked against pending stores, and each load either forwards data, stalls the pipeline, or proceeds straight to memory.

## Interface
- DEPTH, 4: number of store entries; power of two, minimum 2.
- AW, 32: address width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- st_valid  in  1  store request from the MEM stage.
- st_funct3  in  3  store width: 000 = SB, 001 = SH, 010 = SW.
- st_addr  in  AW  store byte address.
- st_data  in  32  store data, LSB-aligned.
- st_ready  out  1  buffer can accept a store this cycle.
- ld_valid  in  1  load in the MEM stage; owns the memory port this cycle.
- ld_funct3  in  3  load type: 000/001/010/100/101.
- ld_addr  in  AW  load byte address.
- ld_hit  out  1  forward ld_fwd_data instead of the memory data.
- ld_conflict  out  1  overlap that cannot be forwarded; the pipeline must stall.
- ld_fwd_data  out  32  forwarded, extended load result.
- fence_req  in  1  drain request from FENCE or ECALL.
- empty  out  1  no pending stores.
- mem_write  out  1  write strobe to data memory.
- mem_funct3  out  3  width of the store being drained.
- mem_addr  out  AW  address of the store being drained.
- mem_wdata  out  32  data of the store being drained.

## Operation
- Circular FIFO with head pointer, tail pointer and count. Each entry holds funct3, addr and data.
- Enqueue: at posedge when st_valid && st_ready. st_ready = (count != DEPTH), and gives no credit for a same-cycle drain. A st_funct3 outside {000, 001, 010} is dropped and never enqueued.
- Drain: mem_write = !empty && (!ld_valid || ld_conflict). mem_* are driven combinationally from the head entry. The head pops at the same posedge.
- Push and pop in the same cycle: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Store byte convention: st_data[7:0] goes to addr, [15:8] to addr+1, and so on.
- Load byte convention: memory returns byte addr as the most-significant byte of the load field.
- Load lookup is combinational over registered entries only. A store enqueued in the same cycle is not visible to the lookup.
- Overlap test: store bytes [addr, addr+S) against load bytes [addr, addr+L). Sizes are 1/2/4, taken from funct3[1:0]. All address arithmetic is AW bits and wraps.
- Select the youngest overlapping entry.
  - If its addr == ld_addr and its size == load size, and no address is involved in a wrap: ld_hit = 1.
  - ld_fwd_data = byte-reversed store field, then zero- or sign-extended per ld_funct3.
  - Any other overlap: ld_conflict = 1 and ld_hit = 0.
- Invalid ld_funct3, or ld_valid = 0: ld_hit = ld_conflict = 0. ld_fwd_data = 0 whenever ld_hit = 0.
- fence_req has no internal state effect. The pipeline holds until empty = 1; draining continues because a fence is not a load.

## Timing
- Reset values: all pointers and count 0, st_ready = 1, empty = 1, mem_write = 0, ld_hit = 0, ld_conflict = 0, ld_fwd_data = 0, mem_* = 0.
- Store accepted at edge N is eligible to drain at edge N+1 at the earliest.
- Store accepted at edge N is visible to a load in cycle N+1.
- Full buffer with ld_valid held high and no conflict: no drain. The pipeline sees st_ready = 0 and the upstream stage resolves the stall.
- Conflict: one entry drains per cycle until the overlap clears. The load then reads memory in the same cycle that ld_conflict falls.
- Reset asserted mid-operation: pending stores are discarded immediately (asynchronous) and the memory write strobe deasserts at once.

## Configuration
- STORE_BUFFER_FORWARD_EN defined: forwarding as described above.
- Undefined: ld_hit is tied to 0, ld_fwd_data to 0, and every overlap raises ld_conflict. The comparators for the exact-match test are not built.

## Structure
- Shared package (core pkg):
  - funct3 load/store constants.
  - sb_entry_t struct (funct3, addr, data).
  - size_of(funct3) function.
- One sub-module, sb_overlap: per-entry byte-range comparator producing overlap and exact-match flags. Instantiated DEPTH times.

## Test plan
- Reset with st_valid high -> nothing enqueued; empty = 1, st_ready = 1, mem_write = 0.
- SW 0x11223344 @0x100, then LW @0x100 next cycle -> ld_hit = 1, ld_fwd_data = 0x44332211, mem_write = 0.
- SB 0x80 @0x203, then LB @0x203 -> ld_fwd_data = 0xFFFFFF80. LBU @0x203 -> 0x00000080.
- SH @0x300, then LW @0x300 -> ld_conflict = 1 and mem_write = 1 for one cycle, then ld_conflict = 0. The same test with the macro undefined, using SW/LW, -> ld_conflict = 1.
- Four stores with ld_valid held high -> st_ready = 0 on the fifth. Drop ld_valid -> stores drain in order at 1/cycle. Push and pop in the same cycle keep count at 3.
- Two SWs to 0x400 (old, then new) -> a load forwards the newer data. fence_req -> empty = 1 after 2 cycles.
